// File: rtl/adc_eth_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_eth_pack: buffers one ADC capture, then frames it as header+data+pad  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adc_eth_pack #(
  parameter int          RX_W = 10,
  parameter int          TX_W = 12,
  parameter logic [15:0] SYNC = 16'hEB90
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fs,
  output logic            fd,
  input  logic [7:0]      cmd_kdev,
  input  logic [RX_W-1:0] adc_rx_len,
  input  logic [TX_W-1:0] eth_tx_len,
  input  logic [7:0]      adc_rxd,
  input  logic            adc_rxv,
  output logic [7:0]      eth_txd,
  output logic            eth_txv,
  input  logic            eth_rdy,
  output logic            err
);

  localparam int            c_depth   = 1 << RX_W;
  localparam logic [TX_W:0] c_hdr_len = (TX_W+1)'(5);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RECV = 3'd1,
    S_HEAD = 3'd2,
    S_DATA = 3'd3,
    S_PAD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          r_state;
  logic [7:0]      r_kdev;
  logic [RX_W-1:0] r_rl;
  logic [RX_W-1:0] r_wcnt;
  logic [RX_W-1:0] r_raddr;
  logic [TX_W-1:0] r_tl;
  logic [TX_W-1:0] r_acnt;
  logic [7:0]      r_mem [c_depth];
  logic [7:0]      r_rdata;

  logic [TX_W:0]   w_tl_ext;
  logic [TX_W:0]   w_hdr_rl;
  logic [TX_W:0]   w_data_end;
  logic [TX_W:0]   w_next_idx;
  logic [TX_W:0]   w_in_tl;
  logic [TX_W:0]   w_in_hdr_rl;
  logic [15:0]     w_rl16;
  logic            w_accept;
  logic            w_last;
  logic            w_rd_adv;
  logic [RX_W-1:0] w_raddr_nxt;
  logic [7:0]      w_next_byte;
  state_t          w_next_state;

  // All length arithmetic is one bit wider than tl so 5+rl never wraps.
  assign w_tl_ext    = {1'b0, r_tl};
  assign w_hdr_rl    = c_hdr_len + (TX_W+1)'(r_rl);
  assign w_data_end  = (w_hdr_rl < w_tl_ext) ? w_hdr_rl : w_tl_ext;
  assign w_in_tl     = {1'b0, eth_tx_len};
  assign w_in_hdr_rl = c_hdr_len + (TX_W+1)'(adc_rx_len);
  assign w_rl16      = 16'(r_rl);
  assign w_accept    = eth_txv & eth_rdy;
  assign w_next_idx  = {1'b0, r_acnt} + (TX_W+1)'(1);
  assign w_last      = (w_next_idx == w_tl_ext);
  assign w_rd_adv    = w_accept && !w_last && (w_next_idx >= c_hdr_len) &&
                       (w_next_idx < w_data_end);
  // Read address runs one step ahead so r_rdata always holds the next data byte.
  assign w_raddr_nxt = r_raddr + RX_W'(w_rd_adv);

  always_comb begin
    w_next_byte  = 8'h00;
    w_next_state = S_PAD;
    if (w_next_idx < c_hdr_len) begin
      w_next_state = S_HEAD;
      case (w_next_idx[2:0])
        3'd0:    w_next_byte = SYNC[15:8];
        3'd1:    w_next_byte = SYNC[7:0];
        3'd2:    w_next_byte = r_kdev;
        3'd3:    w_next_byte = w_rl16[15:8];
        default: w_next_byte = w_rl16[7:0];
      endcase
    end else if (w_next_idx < w_data_end) begin
      w_next_state = S_DATA;
      w_next_byte  = r_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_RECV && adc_rxv) begin
      r_mem[r_wcnt] <= adc_rxd;
    end
    r_rdata <= r_mem[w_raddr_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_kdev  <= '0;
      r_rl    <= '0;
      r_tl    <= '0;
      r_wcnt  <= '0;
      r_raddr <= '0;
      r_acnt  <= '0;
      fd      <= 1'b0;
      err     <= 1'b0;
      eth_txd <= 8'h00;
      eth_txv <= 1'b0;
    end else begin
      r_raddr <= w_raddr_nxt;
      case (r_state)
        S_IDLE: begin
          r_raddr <= '0;
          r_wcnt  <= '0;
          r_acnt  <= '0;
          if (fs) begin
            r_kdev <= cmd_kdev;
            r_rl   <= adc_rx_len;
            r_tl   <= eth_tx_len;
            err    <= (w_in_tl < c_hdr_len) || (w_in_hdr_rl > w_in_tl);
            if (w_in_tl < c_hdr_len) begin
              r_state <= S_DONE;
              fd      <= 1'b1;
            end else if (adc_rx_len != '0) begin
              r_state <= S_RECV;
            end else begin
              r_state <= S_HEAD;
              eth_txd <= SYNC[15:8];
              eth_txv <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (adc_rxv) begin
            r_wcnt <= r_wcnt + RX_W'(1);
            if (r_wcnt == r_rl - RX_W'(1)) begin
              r_state <= S_HEAD;
              eth_txd <= SYNC[15:8];
              eth_txv <= 1'b1;
            end
          end
        end
        S_HEAD, S_DATA, S_PAD: begin
          if (w_accept) begin
            if (w_last) begin
              eth_txv <= 1'b0;
              eth_txd <= 8'h00;
              r_state <= S_DONE;
              fd      <= 1'b1;
            end else begin
              r_acnt  <= r_acnt + TX_W'(1);
              eth_txd <= w_next_byte;
              r_state <= w_next_state;
            end
          end
        end
        S_DONE: begin
          if (!fs) begin
            r_state <= S_IDLE;
            fd      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_eth_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adc_eth_pack: directed frames with a byte scoreboard for adc_eth_pack   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_adc_eth_pack;

  localparam int RX_W = 10;
  localparam int TX_W = 12;

  logic            clk;
  logic            rst_n;
  logic            fs;
  logic            fd;
  logic [7:0]      cmd_kdev;
  logic [RX_W-1:0] adc_rx_len;
  logic [TX_W-1:0] eth_tx_len;
  logic [7:0]      adc_rxd;
  logic            adc_rxv;
  logic [7:0]      eth_txd;
  logic            eth_txv;
  logic            eth_rdy;
  logic            err;

  int         checks   = 0;
  int         failures = 0;
  int         acc_cnt  = 0;
  int         rdy_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] adc_q[$];

  logic [7:0] e_basic[16] = '{8'hEB, 8'h90, 8'h3C, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33,
                              8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] e_trunc[12] = '{8'hEB, 8'h90, 8'h5A, 8'h00, 8'h0A, 8'h01, 8'h02, 8'h03,
                              8'h04, 8'h05, 8'h06, 8'h07};
  logic [7:0] e_hdr[5]    = '{8'hEB, 8'h90, 8'h77, 8'h00, 8'h00};

  adc_eth_pack #(.RX_W(RX_W), .TX_W(TX_W), .SYNC(16'hEB90)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fs         (fs),
    .fd         (fd),
    .cmd_kdev   (cmd_kdev),
    .adc_rx_len (adc_rx_len),
    .eth_tx_len (eth_tx_len),
    .adc_rxd    (adc_rxd),
    .adc_rxv    (adc_rxv),
    .eth_txd    (eth_txd),
    .eth_txv    (eth_txv),
    .eth_rdy    (eth_rdy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: header, first min(rl,tl-5) captured bytes, then zero pad.
  task automatic push_model(input logic [7:0] k, input int rl, input int tl);
    int n;
    if (tl < 5) return;
    exp_q.push_back(8'hEB);
    exp_q.push_back(8'h90);
    exp_q.push_back(k);
    exp_q.push_back(8'((rl >> 8) & 255));
    exp_q.push_back(8'(rl & 255));
    n = (rl < tl - 5) ? rl : tl - 5;
    for (int i = 0; i < n; i++) exp_q.push_back(adc_q[i]);
    for (int i = 0; i < tl - 5 - rl; i++) exp_q.push_back(8'h00);
  endtask

  // Sink ready: always on, or alternating with random extra stalls.
  initial begin
    bit tog;
    tog = 1'b0;
    eth_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      tog = ~tog;
      if (rdy_mode == 0) eth_rdy = 1'b1;
      else eth_rdy = tog & ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every presented byte must be the scoreboard head; pop on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && eth_txv === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none", eth_txd);
        end else begin
          chk("txd", {24'h0, eth_txd}, {24'h0, exp_q[0]});
          if (eth_rdy) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  task automatic run_frame(input logic [7:0] k, input int rl, input int tl,
                           input bit exp_err, input bit ign, input bit drop_fs);
    int n;
    acc_cnt = 0;
    if (ign) begin
      adc_rxd = 8'hA5;
      adc_rxv = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    adc_rxv    = 1'b0;
    cmd_kdev   = k;
    adc_rx_len = RX_W'(rl);
    eth_tx_len = TX_W'(tl);
    fs         = 1'b1;
    @(posedge clk); #1;
    cmd_kdev   = ~k;
    adc_rx_len = '1;
    eth_tx_len = '0;
    if (drop_fs) fs = 1'b0;
    if (tl < 5) begin
      @(negedge clk);
      chk("fd_fast", fd, 1);
    end else begin
      for (int i = 0; i < rl; i++) begin
        adc_rxd = adc_q[i];
        adc_rxv = 1'b1;
        @(posedge clk); #1;
      end
      adc_rxv = 1'b0;
      if (ign) begin
        adc_rxd = 8'hA5;
        adc_rxv = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        adc_rxv = 1'b0;
      end
    end
    n = 0;
    while (fd !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("fd_rise", fd, 1);
    chk("err", err, exp_err);
    chk("byte_count", acc_cnt, (tl < 5) ? 0 : tl);
    chk("queue_empty", exp_q.size(), 0);
    if (drop_fs) begin
      @(negedge clk);
      chk("fd_pulse", fd, 0);
    end else begin
      @(posedge clk); #1;
      fs = 1'b0;
      @(negedge clk);
      chk("fd_hold", fd, 1);
      @(negedge clk);
      chk("fd_fall", fd, 0);
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    fs         = 1'b0;
    cmd_kdev   = 8'h00;
    adc_rx_len = '0;
    eth_tx_len = '0;
    adc_rxd    = 8'h00;
    adc_rxv    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fd", fd, 0);
    chk("rst_txv", eth_txv, 0);
    chk("rst_txd", eth_txd, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Basic frame, sink always ready
    adc_q = {8'h11, 8'h22, 8'h33, 8'h44};
    foreach (e_basic[i]) exp_q.push_back(e_basic[i]);
    run_frame(8'h3C, 4, 16, 1'b0, 1'b0, 1'b0);

    // Same frame under backpressure
    rdy_mode = 1;
    foreach (e_basic[i]) exp_q.push_back(e_basic[i]);
    run_frame(8'h3C, 4, 16, 1'b0, 1'b0, 1'b0);
    rdy_mode = 0;

    // Truncation: rl=10, tl=12
    adc_q.delete();
    for (int i = 1; i <= 10; i++) adc_q.push_back(8'(i));
    foreach (e_trunc[i]) exp_q.push_back(e_trunc[i]);
    run_frame(8'h5A, 10, 12, 1'b1, 1'b0, 1'b0);

    // Header only
    foreach (e_hdr[i]) exp_q.push_back(e_hdr[i]);
    run_frame(8'h77, 0, 5, 1'b0, 1'b0, 1'b0);

    // tl below header size: nothing emitted
    run_frame(8'hC3, 2, 3, 1'b1, 1'b0, 1'b0);

    // Full buffer with stray adc_rxv in IDLE and HEAD
    adc_q.delete();
    for (int i = 0; i < 1023; i++) adc_q.push_back(8'(i));
    push_model(8'hA1, 1023, 1028);
    rdy_mode = 1;
    run_frame(8'hA1, 1023, 1028, 1'b0, 1'b1, 1'b0);
    rdy_mode = 0;

    // Reset during DATA of a truncated frame
    adc_q.delete();
    for (int i = 0; i < 10; i++) adc_q.push_back(8'(8'h21 + i));
    push_model(8'h42, 10, 12);
    acc_cnt = 0;
    @(posedge clk); #1;
    cmd_kdev   = 8'h42;
    adc_rx_len = RX_W'(10);
    eth_tx_len = TX_W'(12);
    fs         = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      adc_rxd = adc_q[i];
      adc_rxv = 1'b1;
      @(posedge clk); #1;
    end
    adc_rxv = 1'b0;
    n = 0;
    while (acc_cnt < 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_err", err, 1);
    chk("pre_rst_txv", eth_txv, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txv", eth_txv, 0);
    chk("mid_rst_fd", fd, 0);
    chk("mid_rst_err", err, 0);
    exp_q.delete();
    fs = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean frame after reset
    adc_q = {8'h11, 8'h22, 8'h33, 8'h44};
    push_model(8'h99, 4, 16);
    run_frame(8'h99, 4, 16, 1'b0, 1'b0, 1'b0);

    // fs dropped while header is being sent
    adc_q.delete();
    push_model(8'h55, 0, 8);
    run_frame(8'h55, 0, 8, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
